// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data width, MemSize encodings, MEM-stage FSM states
// and the alignment predicate used by the optional alignment trap.
package mips_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } memState_t;

  // Size 2'b11 is treated as a word access everywhere.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    case (size)
      SZ_BYTE: isMisaligned = 1'b0;
      SZ_HALF: isMisaligned = addrLo[0];
      default: isMisaligned = |addrLo;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Data-memory lane steering: byte enables, store-data replication, and load lane
// extraction with zero/sign extension. Purely combinational.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]        memSize,
  input  logic [1:0]        addrLo,
  input  logic              memSigned,
  input  logic [DATA_W-1:0] storeData,
  input  logic [DATA_W-1:0] readWord,
  output logic [3:0]        byteEn,
  output logic [DATA_W-1:0] storeWord,
  output logic [DATA_W-1:0] loadData
);

  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  always_comb begin
    case (addrLo)
      2'd0:    loadByte = readWord[7:0];
      2'd1:    loadByte = readWord[15:8];
      2'd2:    loadByte = readWord[23:16];
      default: loadByte = readWord[31:24];
    endcase
    loadHalf = addrLo[1] ? readWord[31:16] : readWord[15:0];
  end

  // Sub-word accesses ignore the address bits below their own size.
  always_comb begin
    byteEn    = 4'b1111;
    storeWord = storeData;
    loadData  = readWord;
    case (memSize)
      SZ_BYTE: begin
        case (addrLo)
          2'd0:    byteEn = 4'b0001;
          2'd1:    byteEn = 4'b0010;
          2'd2:    byteEn = 4'b0100;
          default: byteEn = 4'b1000;
        endcase
        storeWord = {4{storeData[7:0]}};
        loadData  = {{24{memSigned & loadByte[7]}}, loadByte};
      end
      SZ_HALF: begin
        byteEn    = addrLo[1] ? 4'b1100 : 4'b0011;
        storeWord = {2{storeData[15:0]}};
        loadData  = {{16{memSigned & loadHalf[15]}}, loadHalf};
      end
      default: begin
        byteEn    = 4'b1111;
        storeWord = storeData;
        loadData  = readWord;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX/MEM register, data-memory request FSM with wait/timeout, lane steering, MEM/WB register.
// Optional MEM_ALIGN_TRAP_EN: misaligned half/word accesses skip the bus and pulse AlignErr_mem.
//
// state    | meaning
// S_IDLE   | EX/MEM holds a non-memory instruction (or a trapped misaligned access)
// S_ACCESS | EX/MEM holds a load/store; dmem_req asserted until ack or timeout
module mem_stage
  import mips_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_ex,
  input  logic        MemToReg_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic [1:0]  MemSize_ex,
  input  logic        MemSigned_ex,
  input  logic [4:0]  RegWriteAddr_ex,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  RegWriteAddr_mem,
  output logic        RegWrite_mem,
  output logic        Stall_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  RegWriteAddr_wb,
  output logic        RegWrite_wb,
  output logic        BusErr_mem
`ifdef MEM_ALIGN_TRAP_EN
  ,
  output logic        AlignErr_mem
`endif
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(DMEM_TIMEOUT - 1);

  logic              memToReg_q;
  logic              memRead_q;
  logic              memWrite_q;
  logic [1:0]        memSize_q;
  logic              memSigned_q;
  logic [31:0]       storeData_q;

  memState_t         state;
  memState_t         stateNext;
  logic [7:0]        waitCnt;
  logic              timeoutHit;
  logic              capture;
  logic              exIsAccess;
  logic              alignErr;

  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] wbData;

  assign capture = ~Stall_mem;

`ifdef MEM_ALIGN_TRAP_EN
  assign exIsAccess = (MemRead_ex | MemWrite_ex) & ~isMisaligned(MemSize_ex, ALUResult_ex[1:0]);
  assign alignErr   = (memRead_q | memWrite_q) & isMisaligned(memSize_q, ALUResult_mem[1:0]);
  assign AlignErr_mem = alignErr;
`else
  assign exIsAccess = MemRead_ex | MemWrite_ex;
  assign alignErr   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite_mem     <= 1'b0;
      memToReg_q       <= 1'b0;
      memRead_q        <= 1'b0;
      memWrite_q       <= 1'b0;
      memSize_q        <= SZ_BYTE;
      memSigned_q      <= 1'b0;
      RegWriteAddr_mem <= 5'd0;
      ALUResult_mem    <= 32'd0;
      storeData_q      <= 32'd0;
    end else if (capture) begin
      RegWrite_mem     <= RegWrite_ex;
      memToReg_q       <= MemToReg_ex;
      memRead_q        <= MemRead_ex;
      memWrite_q       <= MemWrite_ex;
      memSize_q        <= MemSize_ex;
      memSigned_q      <= MemSigned_ex;
      RegWriteAddr_mem <= RegWriteAddr_ex;
      ALUResult_mem    <= ALUResult_ex;
      storeData_q      <= MemWriteData_ex;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // A completing access hands straight over to whatever is captured on the same edge.
  always_comb begin
    stateNext = state;
    if (capture) begin
      stateNext = exIsAccess ? S_ACCESS : S_IDLE;
    end
  end

  always_comb begin
    dmem_req   = (state == S_ACCESS);
    timeoutHit = (state == S_ACCESS) && (waitCnt == TIMEOUT_LAST) && !dmem_ack;
    Stall_mem  = (state == S_ACCESS) && !dmem_ack && !timeoutHit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCnt <= 8'd0;
    end else if (capture) begin
      waitCnt <= 8'd0;
    end else if ((state == S_ACCESS) && !dmem_ack) begin
      waitCnt <= waitCnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      BusErr_mem <= 1'b0;
    end else if (timeoutHit) begin
      BusErr_mem <= 1'b1;
    end
  end

  mem_lane_align u_laneAlign (
    .memSize   (memSize_q),
    .addrLo    (ALUResult_mem[1:0]),
    .memSigned (memSigned_q),
    .storeData (storeData_q),
    .readWord  (dmem_rdata),
    .byteEn    (dmem_be),
    .storeWord (dmem_wdata),
    .loadData  (loadData)
  );

  assign dmem_we   = memWrite_q;
  assign dmem_addr = {ALUResult_mem[31:2], 2'b00};

  // A timed-out load retires with zero data rather than whatever is on the bus.
  always_comb begin
    wbData = ALUResult_mem;
    if (memToReg_q) begin
      wbData = timeoutHit ? 32'd0 : loadData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteData_wb <= 32'd0;
      RegWriteAddr_wb <= 5'd0;
      RegWrite_wb     <= 1'b0;
    end else if (Stall_mem) begin
      RegWrite_wb     <= 1'b0;
    end else begin
      RegWriteData_wb <= wbData;
      RegWriteAddr_wb <= RegWriteAddr_mem;
      RegWrite_wb     <= RegWrite_mem & ~alignErr;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (default build, DMEM_TIMEOUT = 4).
module tb_mem_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_ex, MemToReg_ex, MemRead_ex, MemWrite_ex, MemSigned_ex;
  logic [1:0]  MemSize_ex;
  logic [4:0]  RegWriteAddr_ex;
  logic [31:0] ALUResult_ex, MemWriteData_ex;
  logic [31:0] ALUResult_mem;
  logic [4:0]  RegWriteAddr_mem;
  logic        RegWrite_mem, Stall_mem, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] RegWriteData_wb;
  logic [4:0]  RegWriteAddr_wb;
  logic        RegWrite_wb, BusErr_mem;

  int vecCount  = 0;
  int missCount = 0;
  int sc;

  mem_stage #(.DMEM_TIMEOUT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .RegWrite_ex      (RegWrite_ex),
    .MemToReg_ex      (MemToReg_ex),
    .MemRead_ex       (MemRead_ex),
    .MemWrite_ex      (MemWrite_ex),
    .MemSize_ex       (MemSize_ex),
    .MemSigned_ex     (MemSigned_ex),
    .RegWriteAddr_ex  (RegWriteAddr_ex),
    .ALUResult_ex     (ALUResult_ex),
    .MemWriteData_ex  (MemWriteData_ex),
    .ALUResult_mem    (ALUResult_mem),
    .RegWriteAddr_mem (RegWriteAddr_mem),
    .RegWrite_mem     (RegWrite_mem),
    .Stall_mem        (Stall_mem),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_be          (dmem_be),
    .dmem_wdata       (dmem_wdata),
    .dmem_rdata       (dmem_rdata),
    .dmem_ack         (dmem_ack),
    .RegWriteData_wb  (RegWriteData_wb),
    .RegWriteAddr_wb  (RegWriteAddr_wb),
    .RegWrite_wb      (RegWrite_wb),
    .BusErr_mem       (BusErr_mem)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic setEx(input logic rw, input logic mtr, input logic mr, input logic mw,
                       input logic [1:0] sz, input logic sgn, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] wd);
    RegWrite_ex     = rw;
    MemToReg_ex     = mtr;
    MemRead_ex      = mr;
    MemWrite_ex     = mw;
    MemSize_ex      = sz;
    MemSigned_ex    = sgn;
    RegWriteAddr_ex = rd;
    ALUResult_ex    = alu;
    MemWriteData_ex = wd;
  endtask

  task automatic setNop();
    setEx(1'b0, 1'b0, 1'b0, 1'b0, SZ_BYTE, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  // Holds off ack for 'waits' negedges, then acks; returns #1 after the completing edge.
  task automatic runAccess(input int waits, input logic [31:0] rdata, output int stallCycles);
    stallCycles = 0;
    for (int i = 0; i < waits; i++) begin
      if (Stall_mem) stallCycles++;
      @(negedge clk);
    end
    dmem_rdata = rdata;
    dmem_ack   = 1'b1;
    #1;
    if (Stall_mem) stallCycles++;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    setNop();
    repeat (2) @(negedge clk);
    checkVal("rst_req",    32'(dmem_req),      32'h0);
    checkVal("rst_stall",  32'(Stall_mem),     32'h0);
    checkVal("rst_rw_wb",  32'(RegWrite_wb),   32'h0);
    checkVal("rst_alu",    ALUResult_mem,      32'h0);
    checkVal("rst_buserr", 32'(BusErr_mem),    32'h0);
    reset = 1'b0;

    // Non-memory op
    setEx(1'b1, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 5'd5, 32'h12345678, 32'h0);
    @(negedge clk);
    checkVal("alu_mem",   ALUResult_mem,           32'h12345678);
    checkVal("rd_mem",    32'(RegWriteAddr_mem),   32'd5);
    checkVal("rw_mem",    32'(RegWrite_mem),       32'h1);
    checkVal("alu_stall", 32'(Stall_mem),          32'h0);
    checkVal("alu_req",   32'(dmem_req),           32'h0);
    setNop();
    @(negedge clk);
    checkVal("alu_wbdata", RegWriteData_wb,        32'h12345678);
    checkVal("alu_wbaddr", 32'(RegWriteAddr_wb),   32'd5);
    checkVal("alu_wbrw",   32'(RegWrite_wb),       32'h1);
    checkVal("alu_stall2", 32'(Stall_mem),         32'h0);

    // Store byte at 0x103, two wait cycles
    setEx(1'b0, 1'b0, 1'b0, 1'b1, SZ_BYTE, 1'b0, 5'd0, 32'h00000103, 32'h000000AB);
    @(negedge clk);
    checkVal("sb_req",   32'(dmem_req), 32'h1);
    checkVal("sb_we",    32'(dmem_we),  32'h1);
    checkVal("sb_addr",  dmem_addr,     32'h00000100);
    checkVal("sb_be",    32'(dmem_be),  32'h8);
    checkVal("sb_wdata", dmem_wdata,    32'hABABABAB);
    setNop();
    runAccess(2, 32'h0, sc);
    checkVal("sb_stallcyc", 32'(sc),          32'd2);
    checkVal("sb_req_end",  32'(dmem_req),    32'h0);
    checkVal("sb_rw_wb",    32'(RegWrite_wb), 32'h0);

    // Store half at 0x40, zero wait
    @(negedge clk);
    setEx(1'b0, 1'b0, 1'b0, 1'b1, SZ_HALF, 1'b0, 5'd0, 32'h00000040, 32'h1234BEEF);
    @(negedge clk);
    checkVal("sh_be",    32'(dmem_be), 32'h3);
    checkVal("sh_wdata", dmem_wdata,   32'hBEEFBEEF);
    checkVal("sh_addr",  dmem_addr,    32'h00000040);
    setNop();
    runAccess(0, 32'h0, sc);
    checkVal("sh_stallcyc", 32'(sc), 32'd0);

    // Back-to-back loads, all zero-wait
    @(negedge clk);
    setEx(1'b1, 1'b1, 1'b1, 1'b0, SZ_HALF, 1'b1, 5'd7, 32'h00000202, 32'h0);
    @(negedge clk);
    checkVal("lh_req",  32'(dmem_req), 32'h1);
    checkVal("lh_we",   32'(dmem_we),  32'h0);
    checkVal("lh_be",   32'(dmem_be),  32'hC);
    checkVal("lh_addr", dmem_addr,     32'h00000200);
    setEx(1'b1, 1'b1, 1'b1, 1'b0, SZ_HALF, 1'b0, 5'd8, 32'h00000202, 32'h0);
    runAccess(0, 32'h8001FFFF, sc);
    checkVal("lh_stallcyc", 32'(sc),             32'd0);
    checkVal("lhs_data",    RegWriteData_wb,     32'hFFFF8001);
    checkVal("lhs_addr",    32'(RegWriteAddr_wb), 32'd7);
    checkVal("lhs_rw",      32'(RegWrite_wb),    32'h1);
    checkVal("b2b_req1",    32'(dmem_req),       32'h1);
    setEx(1'b1, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 5'd9, 32'h00000300, 32'h0);
    runAccess(0, 32'h8001FFFF, sc);
    checkVal("lhu_data",    RegWriteData_wb,     32'h00008001);
    checkVal("lhu_addr",    32'(RegWriteAddr_wb), 32'd8);
    checkVal("b2b_req2",    32'(dmem_req),       32'h1);
    checkVal("lw_be",       32'(dmem_be),        32'hF);
    setEx(1'b1, 1'b1, 1'b1, 1'b0, SZ_BYTE, 1'b1, 5'd10, 32'h00000301, 32'h0);
    runAccess(0, 32'hCAFEBABE, sc);
    checkVal("lw_data",     RegWriteData_wb,     32'hCAFEBABE);
    checkVal("lw_addr",     32'(RegWriteAddr_wb), 32'd9);
    checkVal("b2b_req3",    32'(dmem_req),       32'h1);
    setNop();
    runAccess(0, 32'h1234F600, sc);
    checkVal("lb_data",     RegWriteData_wb,     32'hFFFFFFF6);
    checkVal("lb_addr",     32'(RegWriteAddr_wb), 32'd10);
    checkVal("lb_rw",       32'(RegWrite_wb),    32'h1);
    checkVal("b2b_req_end", 32'(dmem_req),       32'h0);

    // Timeout: ack never comes
    @(negedge clk);
    setEx(1'b1, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 5'd12, 32'hDEADBEEF, 32'h0);
    @(negedge clk);
    setEx(1'b1, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b1, 5'd11, 32'h00000400, 32'h0);
    @(negedge clk);
    checkVal("to_prev_wb", RegWriteData_wb, 32'hDEADBEEF);
    checkVal("to_req",     32'(dmem_req),   32'h1);
    setNop();
    sc = 0;
    for (int i = 0; i < 10 && Stall_mem; i++) begin
      sc++;
      @(negedge clk);
    end
    checkVal("to_stallcyc", 32'(sc),           32'd3);
    checkVal("to_buserr0",  32'(BusErr_mem),   32'h0);
    @(posedge clk);
    #1;
    checkVal("to_data",     RegWriteData_wb,     32'h0);
    checkVal("to_rw",       32'(RegWrite_wb),    32'h1);
    checkVal("to_addr",     32'(RegWriteAddr_wb), 32'd11);
    checkVal("to_buserr1",  32'(BusErr_mem),     32'h1);
    checkVal("to_req_end",  32'(dmem_req),       32'h0);

    // Reset in the middle of an access
    @(negedge clk);
    setEx(1'b1, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 5'd13, 32'h55AA55AA, 32'h0);
    @(negedge clk);
    setEx(1'b1, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 5'd14, 32'h00000500, 32'h0);
    @(negedge clk);
    checkVal("ra_buserr_sticky", 32'(BusErr_mem),  32'h1);
    checkVal("ra_req",           32'(dmem_req),    32'h1);
    checkVal("ra_stall",         32'(Stall_mem),   32'h1);
    checkVal("ra_rw_wb",         32'(RegWrite_wb), 32'h1);
    setNop();
    reset = 1'b1;
    #1;
    checkVal("ra_req_rst",    32'(dmem_req),    32'h0);
    checkVal("ra_stall_rst",  32'(Stall_mem),   32'h0);
    checkVal("ra_rw_rst",     32'(RegWrite_wb), 32'h0);
    checkVal("ra_buserr_rst", 32'(BusErr_mem),  32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkVal("ra_req_idle",   32'(dmem_req),    32'h0);
    checkVal("ra_stall_idle", 32'(Stall_mem),   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
